// File: rtl/mem_store_unit_pkg.sv
// mem_store_unit_pkg: store-width encodings, FSM states and request check
package mem_store_unit_pkg;
  localparam logic [1:0] ST_WORD = 2'b00;
  localparam logic [1:0] ST_HALF = 2'b01;
  localparam logic [1:0] ST_BYTE = 2'b10;
  localparam logic [1:0] ST_RSVD = 2'b11;
  typedef enum logic [2:0] {MS_IDLE, MS_READ, MS_WAIT, MS_WRITE, MS_DONE, MS_ERR} ms_state_e;
  function automatic logic bad_req(input logic [1:0] op, input logic [1:0] off);
    return op == ST_RSVD || (op == ST_HALF && off[0]) || (op == ST_WORD && off != 2'b00);
  endfunction
endpackage

// File: rtl/mem_store_unit_store_merge.sv
// store_merge: splices a word/half/byte into the old RAM word (big-endian lanes)
module store_merge
  import mem_store_unit_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  op,
  input  logic [1:0]  offset,
  output logic [31:0] merged
);
  logic [4:0] sh;
  assign sh = {~offset, 3'b000};
  // byte offset 0 is the most significant lane, so the shift is (3-offset)*8
  always_comb
    merged = op == ST_WORD ? new_data :
             op == ST_HALF ? (offset[1] ? {old_word[31:16], new_data[15:0]}
                                        : {new_data[15:0], old_word[15:0]}) :
             (old_word & ~(32'hFF << sh)) | ({24'b0, new_data[7:0]} << sh);
endmodule

// File: rtl/mem_store_unit.sv
// mem_store_unit: word/half/byte store into a word-only RAM via read-modify-write
module mem_store_unit
  import mem_store_unit_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        st_op,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              misalign
);
  ms_state_e         state_q, state_d;
  logic [MEM_AW+1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d, rdata_q, rdata_d;
  logic [1:0]        op_q, op_d;
  logic              unused_hi;
  assign unused_hi = ^addr[31:MEM_AW+2];
  // next-state and register capture; requests are only taken in IDLE
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    op_d    = op_q;
    rdata_d = rdata_q;
    case (state_q)
      MS_IDLE: if (start) begin
        addr_d  = addr[MEM_AW+1:0];
        data_d  = wdata;
        op_d    = st_op;
        state_d = bad_req(st_op, addr[1:0]) ? MS_ERR : st_op == ST_WORD ? MS_WRITE : MS_READ;
      end
      MS_READ:  state_d = MS_WAIT;
      MS_WAIT: begin
        rdata_d = mem_rdata;
        state_d = MS_WRITE;
      end
      MS_WRITE: state_d = MS_DONE;
      default:  state_d = MS_IDLE;
    endcase
  end
  // state and latched request; reset abandons any store in flight
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= MS_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      op_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      op_q    <= op_d;
      rdata_q <= rdata_d;
    end
  store_merge u_merge (
    .old_word(rdata_q),
    .new_data(data_q),
    .op      (op_q),
    .offset  (addr_q[1:0]),
    .merged  (mem_wdata)
  );
  assign mem_addr  = addr_q[MEM_AW+1:2];
  assign mem_rd_en = state_q == MS_READ;
  assign mem_wr_en = state_q == MS_WRITE;
  assign busy      = state_q != MS_IDLE;
  assign done      = state_q == MS_DONE;
  assign misalign  = state_q == MS_ERR;
endmodule

// File: tb/tb_mem_store_unit.sv
// tb_mem_store_unit: directed vector table plus multi-cycle corner sequences
module tb_mem_store_unit;
  import mem_store_unit_pkg::*;
  localparam int MEM_AW = 10;
  logic              clk = 0, rst = 1, start = 0;
  logic [1:0]        st_op = 0;
  logic [31:0]       addr = 0, wdata = 0, mem_rdata = 0, mem_wdata;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd_en, mem_wr_en, busy, done, misalign;
  int                tests = 0, fails = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    logic        err;
  } vec_t;
  vec_t vecs[14];

  mem_store_unit #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst), .start(start), .st_op(st_op), .addr(addr), .wdata(wdata),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_rd_en) mem_rdata <= (mem_addr == 4) ? 32'h11223344 : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int rd_c = 0, wr_c = 0, dn_c = 0, er_c = 0, nwr = 0, busy1 = 0, busy_end = 1, ovl = 0;
    int end_c;
    logic [31:0] wd = 0;
    logic [MEM_AW-1:0] wa = 0;
    end_c = v.err ? 2 : (v.op == ST_WORD ? 3 : 5);
    @(negedge clk);
    st_op = v.op; addr = v.a; wdata = v.d; start = 1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 0;
      if (mem_rd_en && rd_c == 0) rd_c = c;
      if (mem_wr_en) begin nwr++; if (wr_c == 0) wr_c = c; wd = mem_wdata; wa = mem_addr; end
      if (done && dn_c == 0) dn_c = c;
      if (misalign && er_c == 0) er_c = c;
      if (mem_rd_en && mem_wr_en) ovl = 1;
      if (c == 1) busy1 = int'(busy);
      if (c == end_c) busy_end = int'(busy);
    end
    chk($sformatf("busy_t1 %h", v.a), busy1, 1);
    chk($sformatf("busy_end %h", v.a), busy_end, 0);
    chk($sformatf("rd_wr_overlap %h", v.a), ovl, 0);
    if (v.err) begin
      chk($sformatf("misalign_cycle %h op%0d", v.a, v.op), er_c, 1);
      chk($sformatf("err_writes %h op%0d", v.a, v.op), nwr, 0);
      chk($sformatf("err_done %h op%0d", v.a, v.op), dn_c, 0);
    end else begin
      chk($sformatf("rd_cycle %h", v.a), rd_c, v.op == ST_WORD ? 0 : 1);
      chk($sformatf("wr_cycle %h", v.a), wr_c, v.op == ST_WORD ? 1 : 3);
      chk($sformatf("done_cycle %h", v.a), dn_c, v.op == ST_WORD ? 2 : 4);
      chk($sformatf("nwrites %h", v.a), nwr, 1);
      chk($sformatf("wdata %h", v.a), wd, v.exp);
      chk($sformatf("waddr %h", v.a), 32'(wa), 4);
      chk($sformatf("no_misalign %h", v.a), er_c, 0);
    end
  endtask

  initial begin
    int nwr, ndn;
    logic [31:0] wd;
    vecs[0]  = '{ST_WORD, 32'h10,       32'hDEADBEEF, 32'hDEADBEEF, 0};
    vecs[1]  = '{ST_BYTE, 32'h10,       32'h000000AA, 32'hAA223344, 0};
    vecs[2]  = '{ST_BYTE, 32'h11,       32'h000000AA, 32'h11AA3344, 0};
    vecs[3]  = '{ST_BYTE, 32'h12,       32'h000000AA, 32'h1122AA44, 0};
    vecs[4]  = '{ST_BYTE, 32'h13,       32'h000000AA, 32'h112233AA, 0};
    vecs[5]  = '{ST_HALF, 32'h12,       32'hFFFF5566, 32'h11225566, 0};
    vecs[6]  = '{ST_HALF, 32'h10,       32'hFFFF5566, 32'h55663344, 0};
    vecs[7]  = '{ST_HALF, 32'h11,       32'hFFFF5566, 32'h0,        1};
    vecs[8]  = '{ST_WORD, 32'h12,       32'hDEADBEEF, 32'h0,        1};
    vecs[9]  = '{ST_RSVD, 32'h10,       32'hDEADBEEF, 32'h0,        1};
    vecs[10] = '{ST_WORD, 32'h1010,     32'hCAFEF00D, 32'hCAFEF00D, 0};
    vecs[11] = '{ST_BYTE, 32'h80001013, 32'h123456EE, 32'h112233EE, 0};
    vecs[12] = '{ST_HALF, 32'hFFFFF012, 32'h0000ABCD, 32'h1122ABCD, 0};
    vecs[13] = '{ST_RSVD, 32'h13,       32'h0,        32'h0,        1};

    #13;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_misalign", 32'(misalign), 0);
    chk("rst_rd_wr", {30'b0, mem_rd_en, mem_wr_en}, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_addr", 32'(mem_addr), 0);
    @(negedge clk) rst = 0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    nwr = 0; ndn = 0; wd = 0;
    @(negedge clk);
    st_op = ST_BYTE; addr = 32'h11; wdata = 32'hAA; start = 1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (mem_wr_en) begin nwr++; wd = mem_wdata; end
      if (done) ndn++;
      st_op = ST_WORD; addr = 32'h20; wdata = 32'h12345678;
      start = (c <= 2);
    end
    chk("repulse_writes", nwr, 1);
    chk("repulse_dones", ndn, 1);
    chk("repulse_wdata", wd, 32'h11AA3344);
    chk("repulse_idle_t5", 32'(busy), 0);
    st_op = ST_WORD; addr = 32'h10; wdata = 32'hDEADBEEF; start = 1;
    @(negedge clk);
    start = 0;
    chk("t5_accept_wr", 32'(mem_wr_en), 1);
    chk("t5_accept_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("t5_accept_done", 32'(done), 1);

    @(negedge clk);
    st_op = ST_BYTE; addr = 32'h12; wdata = 32'hAA; start = 1;
    @(negedge clk) start = 0;
    @(negedge clk);
    chk("pre_rst_in_wait", 32'(busy), 1);
    #2 rst = 1;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_rd", 32'(mem_rd_en), 0);
    chk("async_rst_wr", 32'(mem_wr_en), 0);
    nwr = 0;
    repeat (2) begin @(negedge clk); if (mem_wr_en) nwr++; end
    rst = 0;
    repeat (4) begin @(negedge clk); if (mem_wr_en || busy) nwr++; end
    chk("rst_abandon_write", nwr, 0);
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_store_unit.md
Name: mem_store_unit

Overview:
Store-side data-memory unit for the multi-cycle MIPS datapath. It narrows a 32-bit register value to word, halfword or byte width (SW/SH/SB) and places it into a word-only synchronous data memory. Sub-word stores use a read-modify-write sequence. The block sits between the datapath's MEM stage control and the data RAM. The controller holds in the MEM state until done is asserted.

Parameters:
MEM_AW, 10, word-address width of the data RAM; memory depth is 2^MEM_AW words.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
st_op  in  2  store width: `ST_WORD=2'b00, `ST_HALF=2'b01, `ST_BYTE=2'b10; 2'b11 reserved
addr  in  32  byte address from the ALU
wdata  in  32  rt register value to store
mem_addr  out  MEM_AW  word address to the RAM, equal to addr_q[MEM_AW+1:2]
mem_rd_en  out  1  RAM read strobe; rdata is valid one cycle later
mem_rdata  in  32  RAM read data
mem_wr_en  out  1  RAM write strobe
mem_wdata  out  32  merged word to write
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
misalign  out  1  one-cycle error pulse; no write occurs

Behaviour:
- Reset (asynchronous): state=IDLE. All outputs are 0. Internal registers addr_q, data_q, op_q and rdata_q are 0.
- Reset while mid-operation: mem_wr_en and mem_rd_en drop immediately. The store in flight is abandoned.
- The FSM states are IDLE, READ, WAIT, WRITE, DONE and ERR.
- Outputs are Moore-decoded from state and the latched registers.
- IDLE, when start=1: latch addr, wdata and st_op.
  - If the op is misaligned or reserved, go to ERR.
  - If the op is WORD, go to WRITE.
  - Otherwise go to READ.
- Misaligned is defined as: HALF with addr[0]=1, or WORD with addr[1:0]!=0. st_op=2'b11 is always an error.
- READ: mem_rd_en=1 for one cycle, then go to WAIT.
- WAIT: rdata_q<=mem_rdata, then go to WRITE.
- WRITE: mem_wr_en=1 for one cycle, then go to DONE.
- DONE: done=1, then go to IDLE.
- ERR: misalign=1 for one cycle, then go to IDLE. mem_wr_en is never asserted.
- Byte order is big-endian: byte offset 0 occupies bits [31:24].
- Merge rules for mem_wdata:
  - WORD: data_q.
  - HALF: replace bits [31:16] (offset 0) or bits [15:0] (offset 2) with data_q[15:0]. The other half comes from rdata_q.
  - BYTE: replace lane (3-offset)*8+:8 with data_q[7:0]. The remaining lanes come from rdata_q.
- Latency, with start at cycle T:
  - WORD: write at T+1, done at T+2.
  - HALF/BYTE: read at T+1, capture at T+2, write at T+3, done at T+4.
  - Error: misalign at T+1.
- start asserted while busy=1 is ignored; it is not queued.
- start is accepted again in the cycle after done or misalign (IDLE).
- mem_addr holds addr_q throughout the operation. Address bits above MEM_AW+1 are ignored (wrap-around).
- mem_rd_en and mem_wr_en are never high in the same cycle.

Decomposition:
- DEFINE.v (shared macro file) gains:
  - `ST_WORD, `ST_HALF, `ST_BYTE encodings.
  - FSM state encodings `MS_IDLE .. `MS_ERR.
- One combinational sub-module, store_merge, with inputs old_word[32], new_data[32], op[2] and offset[2], and output merged[32]. The FSM instantiates it on rdata_q/data_q.

Test Plan:
- SW: addr=0x0000_0010, wdata=0xDEADBEEF -> mem_wr_en at T+1 with mem_addr=4 and mem_wdata=0xDEADBEEF; done at T+2; mem_rd_en never asserted.
- SB, all four offsets: RAM word 4 = 0x11223344, wdata=0x000000AA.
  - addr=0x10 -> 0xAA223344
  - addr=0x11 -> 0x11AA3344
  - addr=0x12 -> 0x1122AA44
  - addr=0x13 -> 0x112233AA
  - Each: read at T+1, write at T+3, done at T+4.
- SH: RAM=0x11223344, wdata=0xFFFF5566.
  - addr=0x12 -> mem_wdata=0x11225566
  - addr=0x10 -> mem_wdata=0x55663344
- Misaligned and reserved requests, each -> misalign pulse at T+1, mem_wr_en stays 0, busy low from T+2:
  - SH at addr=0x11
  - SW at addr=0x12
  - st_op=2'b11
- start re-pulsed at T+1 and T+2 during an SB -> ignored; exactly one write and one done; a new start at T+5 is accepted.
- rst asserted asynchronously mid-WAIT of an SB -> busy, mem_rd_en and mem_wr_en go 0 immediately; no write occurs; after release, an SW completes normally.
